// File: rtl/bp_fe_realigner.sv
`default_nettype none
// ============================================================================
// bp_fe_realigner: turns fetch packets of 16-bit parcels into one instruction
// per cycle, stitching 32-bit instructions that straddle two packets.
// Define BP_FE_REALIGNER_COMPRESSED_EN for RVC support (default: 32-bit only).
// Revision: 1.0
// ============================================================================
module bp_fe_realigner #(
  parameter int vaddr_width_p   = 39,
  parameter int fetch_parcels_p = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         redirect_v_i,
  input  logic [vaddr_width_p-1:0]     redirect_pc_i,
  input  logic                         fetch_v_i,
  input  logic [vaddr_width_p-1:0]     fetch_pc_i,
  input  logic [16*fetch_parcels_p-1:0] fetch_data_i,
  output logic                         fetch_ready_o,
  output logic                         instr_v_o,
  output logic [vaddr_width_p-1:0]     instr_pc_o,
  output logic [31:0]                  instr_o,
  output logic                         instr_compressed_o,
  output logic                         instr_partial_o,
  input  logic                         instr_yumi_i
);
  localparam int LG = $clog2(fetch_parcels_p);
  localparam int CW = LG + 1;

  logic                          buf_v_r;
  logic [vaddr_width_p-1:0]      buf_pc_r;
  logic [16*fetch_parcels_p-1:0] buf_data_r;
  logic [CW-1:0]                 cursor_r;
  logic [LG-1:0]                 skip_r;

  logic [15:0] parcels [fetch_parcels_p];
  for (genvar g = 0; g < fetch_parcels_p; g++) begin : g_parcels
    assign parcels[g] = buf_data_r[16*g +: 16];
  end

  logic [LG-1:0]            cur_idx;
  logic [15:0]              p;
  logic [15:0]              nxt;
  logic [vaddr_width_p-1:0] cur_pc;
  assign cur_idx = cursor_r[LG-1:0];
  assign p       = parcels[cur_idx];
  assign nxt     = parcels[cur_idx + LG'(1)];
  assign cur_pc  = buf_pc_r + {{(vaddr_width_p-CW-1){1'b0}}, cursor_r, 1'b0};

`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  logic                     part_v_r;
  logic [15:0]              part_r;
  logic [vaddr_width_p-1:0] part_pc_r;
`endif

  logic          capture;
  logic [CW-1:0] consume;

  always_comb begin
    instr_o            = {nxt, p};
    instr_pc_o         = cur_pc;
    instr_compressed_o = 1'b0;
    instr_partial_o    = 1'b0;
    consume            = CW'(2);
    capture            = 1'b0;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    if (part_v_r) begin
      instr_o         = {p, part_r};
      instr_pc_o      = part_pc_r;
      instr_partial_o = 1'b1;
      consume         = CW'(1);
    end else if (p[1:0] != 2'b11) begin
      instr_o            = {16'h0000, p};
      instr_compressed_o = 1'b1;
      consume            = CW'(1);
    end else if (cur_idx == LG'(fetch_parcels_p-1)) begin
      // lower half sits in the last parcel: park it until the next packet
      capture = buf_v_r;
    end
`endif
  end

  logic [CW-1:0] cursor_adv;
  logic          fire;
  logic          last;
  logic          drain;
  logic          accept;
  logic [LG-1:0] redirect_skip;

  assign instr_v_o     = buf_v_r & ~capture & ~redirect_v_i;
  assign fire          = instr_v_o & instr_yumi_i;
  assign cursor_adv    = cursor_r + consume;
  assign last          = (cursor_adv >= CW'(fetch_parcels_p));
  assign drain         = (fire & last) | capture;
  assign fetch_ready_o = ~reset_i & ~redirect_v_i & (~buf_v_r | drain);
  assign accept        = fetch_v_i & fetch_ready_o;

`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  assign redirect_skip = redirect_pc_i[1 +: LG];
  // the partial that survives this cycle, including one captured right now
  logic                     part_keep;
  logic [vaddr_width_p-1:0] part_pc_eff;
  assign part_keep   = (part_v_r & ~fire) | capture;
  assign part_pc_eff = capture ? cur_pc : part_pc_r;
`else
  assign redirect_skip = redirect_pc_i[1 +: LG] & ~LG'(1);
`endif

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{redirect_pc_i[vaddr_width_p-1:LG+1], redirect_pc_i[0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_v_r    <= 1'b0;
      buf_pc_r   <= '0;
      buf_data_r <= '0;
      cursor_r   <= '0;
      skip_r     <= '0;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
      part_v_r   <= 1'b0;
      part_r     <= '0;
      part_pc_r  <= '0;
`endif
    end else if (redirect_v_i) begin
      buf_v_r  <= 1'b0;
      skip_r   <= redirect_skip;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
      part_v_r <= 1'b0;
`endif
    end else begin
      if (fire) begin
        cursor_r <= cursor_adv;
        if (last) buf_v_r <= 1'b0;
      end
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
      if (fire && part_v_r) part_v_r <= 1'b0;
      if (capture) begin
        buf_v_r   <= 1'b0;
        part_v_r  <= 1'b1;
        part_r    <= p;
        part_pc_r <= cur_pc;
      end
`endif
      if (accept) begin
        buf_v_r    <= 1'b1;
        buf_pc_r   <= fetch_pc_i;
        buf_data_r <= fetch_data_i;
        cursor_r   <= {1'b0, skip_r};
        skip_r     <= '0;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
        if (part_keep && (fetch_pc_i != part_pc_eff + vaddr_width_p'(2)))
          part_v_r <= 1'b0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_realigner.sv
`default_nettype none
// ============================================================================
// tb_bp_fe_realigner: scoreboard bench for bp_fe_realigner; RVC scenarios are
// included when BP_FE_REALIGNER_COMPRESSED_EN is defined.
// Revision: 1.0
// ============================================================================
module tb_bp_fe_realigner;
  localparam int VW = 39;
  localparam int P  = 2;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redirect_v = 1'b0;
  logic [VW-1:0] redirect_pc = '0;
  logic          fetch_v = 1'b0;
  logic [VW-1:0] fetch_pc = '0;
  logic [31:0]   fetch_data = '0;
  logic          fetch_ready;
  logic          instr_v;
  logic [VW-1:0] instr_pc;
  logic [31:0]   instr;
  logic          instr_c;
  logic          instr_part;
  logic          yumi_en = 1'b0;
  logic          yumi;

  assign yumi = yumi_en & instr_v;

  always #5 clk = ~clk;

  bp_fe_realigner #(.vaddr_width_p(VW), .fetch_parcels_p(P)) dut (
    .clk_i(clk), .reset_i(reset),
    .redirect_v_i(redirect_v), .redirect_pc_i(redirect_pc),
    .fetch_v_i(fetch_v), .fetch_pc_i(fetch_pc), .fetch_data_i(fetch_data),
    .fetch_ready_o(fetch_ready),
    .instr_v_o(instr_v), .instr_pc_o(instr_pc), .instr_o(instr),
    .instr_compressed_o(instr_c), .instr_partial_o(instr_part),
    .instr_yumi_i(yumi)
  );

  typedef struct packed {
    logic [31:0]   instr;
    logic [VW-1:0] pc;
    logic          c;
    logic          part;
  } exp_t;

  exp_t  exp_q[$];
  string scen = "init";
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && instr_v && yumi) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected_instr got instr=%h pc=%h", scen, instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({instr, instr_pc, instr_c, instr_part} !== e) begin
          failures++;
          $display("FAIL %s instr got instr=%h pc=%h c=%b part=%b expected instr=%h pc=%h c=%b part=%b",
                   scen, instr, instr_pc, instr_c, instr_part, e.instr, e.pc, e.c, e.part);
        end
      end
    end
  end

  function automatic void push_exp(input logic [31:0] i, input logic [VW-1:0] pc,
                                   input logic c, input logic part);
    exp_t e;
    e.instr = i; e.pc = pc; e.c = c; e.part = part;
    exp_q.push_back(e);
  endfunction

  task automatic send_pkt(input logic [VW-1:0] pc, input logic [31:0] data);
    int n;
    n = 0;
    fetch_v = 1'b1; fetch_pc = pc; fetch_data = data;
    do begin @(negedge clk); n++; end while (!fetch_ready && n < 40);
    checks++;
    if (!fetch_ready) begin
      failures++;
      $display("FAIL %s pkt_accept_timeout ready=%b expected 1", scen, fetch_ready);
    end
    @(posedge clk); #1;
    fetch_v = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); n++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    scen = "reset";
    reset = 1'b1; #1;
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", instr_v); end
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b expected 0", fetch_ready); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b expected 1", fetch_ready); end
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL post_reset_valid got %b expected 0", instr_v); end
  endtask

`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  task automatic test_rvc_pair();
    scen = "rvc_pair"; yumi_en = 1'b1;
    push_exp(32'h00004501, 39'h80000000, 1'b1, 1'b0);
    push_exp(32'h00004505, 39'h80000002, 1'b1, 1'b0);
    @(posedge clk); #1;
    send_pkt(39'h80000000, {16'h4505, 16'h4501});
    #1;
    checks++; if (instr_v !== 1'b1 || instr !== 32'h00004501) begin
      failures++; $display("FAIL rvc_first_latency got v=%b instr=%h expected v=1 instr=00004501", instr_v, instr); end
    @(posedge clk); #1;
    checks++; if (instr !== 32'h00004505 || fetch_ready !== 1'b1) begin
      failures++; $display("FAIL rvc_second_ready got instr=%h ready=%b expected 00004505 1", instr, fetch_ready); end
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rvc_pair_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_straddle();
    scen = "straddle"; yumi_en = 1'b1;
    push_exp(32'h00004501, 39'h80000000, 1'b1, 1'b0);
    push_exp(32'h00A00513, 39'h80000002, 1'b0, 1'b1);
    push_exp(32'h00004505, 39'h80000006, 1'b1, 1'b0);
    @(posedge clk); #1;
    send_pkt(39'h80000000, {16'h0513, 16'h4501});
    @(posedge clk); #1;
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL straddle_bubble got v=%b expected 0", instr_v); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL capture_ready got %b expected 1", fetch_ready); end
    send_pkt(39'h80000004, {16'h4505, 16'h00A0});
    #1;
    checks++; if (instr_part !== 1'b1) begin failures++; $display("FAIL straddle_partial got %b expected 1", instr_part); end
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL straddle_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_discontinuity();
    scen = "discontinuity"; yumi_en = 1'b1;
    push_exp(32'h00004501, 39'h80000000, 1'b1, 1'b0);
    @(posedge clk); #1;
    send_pkt(39'h80000000, {16'h0513, 16'h4501});
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL partial_held_valid got %b expected 0", instr_v); end
    push_exp(32'h00004501, 39'h80000200, 1'b1, 1'b0);
    push_exp(32'h00004505, 39'h80000202, 1'b1, 1'b0);
    send_pkt(39'h80000200, {16'h4505, 16'h4501});
    #1;
    checks++; if (instr_part !== 1'b0 || instr_pc !== 39'h80000200) begin
      failures++; $display("FAIL partial_dropped got part=%b pc=%h expected 0 80000200", instr_part, instr_pc); end
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL discontinuity_pending got %0d expected 0", exp_q.size()); end
  endtask
`endif

  task automatic test_full_word();
    scen = "full_word"; yumi_en = 1'b1;
    push_exp(32'h00A00513, 39'h80000000, 1'b0, 1'b0);
    @(posedge clk); #1;
    send_pkt(39'h80000000, 32'h00A00513);
    #1;
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL full_word_free got %b expected 1", fetch_ready); end
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_word_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    scen = "redirect"; yumi_en = 1'b0;
    @(posedge clk); #1;
    send_pkt(39'h80000300, {16'h4505, 16'h4501});
    @(posedge clk); #1;
    checks++; if (instr_v !== 1'b1 || fetch_ready !== 1'b0) begin
      failures++; $display("FAIL backpressure got v=%b ready=%b expected 1 0", instr_v, fetch_ready); end
    redirect_v = 1'b1; redirect_pc = 39'h80000102; #1;
    checks++; if (instr_v !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++; $display("FAIL redirect_cycle got v=%b ready=%b expected 0 0", instr_v, fetch_ready); end
    @(posedge clk); #1;
    redirect_v = 1'b0; #1;
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL redirect_flush got v=%b expected 0", instr_v); end
    yumi_en = 1'b1;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    push_exp(32'h00004505, 39'h80000102, 1'b1, 1'b0);
`else
    push_exp(32'h45054501, 39'h80000100, 1'b0, 1'b0);
`endif
    send_pkt(39'h80000100, {16'h4505, 16'h4501});
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redirect_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    scen = "async_reset";
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    yumi_en = 1'b1;
    push_exp(32'h00004501, 39'h80000400, 1'b1, 1'b0);
`else
    yumi_en = 1'b0;
`endif
    @(posedge clk); #1;
    send_pkt(39'h80000400, {16'h4505, 16'h4501});
    @(posedge clk); #1;
    yumi_en = 1'b0;
    #2 reset = 1'b1; #1;
    checks++; if (instr_v !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++; $display("FAIL async_reset got v=%b ready=%b expected 0 0", instr_v, fetch_ready); end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++; if (instr_v !== 1'b0) begin failures++; $display("FAIL stale_after_reset got v=%b expected 0", instr_v); end
    yumi_en = 1'b1;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    push_exp(32'h00004501, 39'h80000400, 1'b1, 1'b0);
    push_exp(32'h00004505, 39'h80000402, 1'b1, 1'b0);
`else
    push_exp(32'h45054501, 39'h80000400, 1'b0, 1'b0);
`endif
    send_pkt(39'h80000400, {16'h4505, 16'h4501});
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL async_reset_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]   r;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [VW-1:0] pc;
    int            prev;
    scen = "back_to_back"; yumi_en = 1'b1; prev = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      r  = $urandom();
      pc = 39'h80001000 + VW'(4 * k);
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
      a = {r[15:2], 2'b01};
      b = {r[31:18], 2'b10};
      push_exp({16'h0000, a}, pc, 1'b1, 1'b0);
      push_exp({16'h0000, b}, pc + 39'd2, 1'b1, 1'b0);
`else
      a = r[15:0];
      b = r[31:16];
      push_exp({b, a}, pc, 1'b0, 1'b0);
`endif
      send_pkt(pc, {b, a});
      if (k > 0) begin
        checks++;
        if (cyc - prev != GAP) begin
          failures++; $display("FAIL accept_gap got %0d expected %0d", cyc - prev, GAP);
        end
      end
      prev = cyc;
    end
    wait_idle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL back_to_back_pending got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    test_rvc_pair();
`endif
    test_full_word();
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
    test_straddle();
    test_discontinuity();
`endif
    test_redirect();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_fe_realigner.md
Name: bp_fe_realigner

Overview:
- Sits between the I$ fetch-data return and the scan/override logic of the PC generator.
- Takes fetch-width packets of 16-bit parcels and emits one instruction per cycle: a 16-bit RVC instruction zero-extended, or a 32-bit instruction.
- Stitches any 32-bit instruction that straddles two consecutive packets into one instruction.
- Its output feeds the fetch-scan input, the fetch-PC input and the fetch-valid input of the PC generator.

Parameters:
- vaddr_width_p, 39: virtual address width.
- fetch_parcels_p, 2: 16-bit parcels per fetch packet; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- redirect_v_i  in  1  flush; takes priority over every other event.
- redirect_pc_i  in  vaddr_width_p  redirect target; bits [1 +: log2(fetch_parcels_p)] give the starting parcel of the next packet.
- fetch_v_i  in  1  packet valid.
- fetch_pc_i  in  vaddr_width_p  packet PC, aligned to 2*fetch_parcels_p bytes.
- fetch_data_i  in  16*fetch_parcels_p  packet parcels; parcel 0 is in the LSBs.
- fetch_ready_o  out  1  packet accepted when fetch_v_i & fetch_ready_o.
- instr_v_o  out  1  instruction valid.
- instr_pc_o  out  vaddr_width_p  instruction PC.
- instr_o  out  32  instruction; RVC is zero-extended.
- instr_compressed_o  out  1  instruction is RVC.
- instr_partial_o  out  1  instruction straddled two packets.
- instr_yumi_i  in  1  consumer takes the instruction; legal only when instr_v_o is high.

Behaviour:
- State registers:
  - buf_v_r, buf_pc_r, buf_data_r, cursor_r (parcel index).
  - part_v_r, part_r (16 bits), part_pc_r.
  - skip_r (start parcel for the next accepted packet).
- Reset (asynchronous): all state is cleared to 0. While in reset, instr_v_o=0 and fetch_ready_o=0.
- Current parcel: p = buf_data_r[16*cursor_r +: 16]. Decode when buf_v_r=1, in priority order:
  1. part_v_r=1: instr_o={p, part_r}, instr_pc_o=part_pc_r, instr_partial_o=1, compressed=0; consumes 1 parcel.
  2. p[1:0]!=2'b11: instr_o={16'h0, p}, compressed=1; consumes 1 parcel.
  3. cursor_r < fetch_parcels_p-1: instr_o={next parcel, p}, compressed=0; consumes 2 parcels.
  4. Otherwise (lower half of a 32-bit instruction in the last parcel): capture cycle. instr_v_o=0; on the clock edge part_r<=p, part_pc_r<=buf_pc_r+2*cursor_r, part_v_r<=1, buf_v_r<=0.
- instr_pc_o = buf_pc_r + 2*cursor_r, except in case 1. Arithmetic is mod 2^vaddr_width_p.
- instr_v_o = buf_v_r & ~capture & ~redirect_v_i.
- On instr_yumi_i:
  - cursor_r advances by the number of parcels consumed; case 1 also clears part_v_r.
  - If the cursor reaches fetch_parcels_p, buf_v_r clears.
- drain = (yumi consuming the final parcel(s)) | capture.
- fetch_ready_o = ~redirect_v_i & (~buf_v_r | drain). This path is combinational from instr_yumi_i.
- Packet accept:
  - buf_v_r<=1, buf_pc_r<=fetch_pc_i, buf_data_r<=fetch_data_i, cursor_r<=skip_r, skip_r<=0.
  - If part_v_r=1 and fetch_pc_i != part_pc_r+2 (discontinuity), part_v_r<=0 and the partial is silently dropped.
- Redirect cycle:
  - buf_v_r<=0, part_v_r<=0, skip_r<=redirect_pc_i parcel bits; no accept, no output.
  - A redirect in the same cycle as a yumi still flushes; the yumi is ignored.
- Latency:
  - An accepted packet shows its first instruction on the next cycle.
  - Back-to-back single-parcel consumption gives 1 instruction per cycle.
  - A capture costs 1 bubble cycle.
- A 32-bit instruction that fits wholly in a packet is never split.

Optional Feature:
- Macro: BP_FE_REALIGNER_COMPRESSED_EN.
- Defined: full RVC behaviour as above.
- Undefined:
  - Every instruction is 32 bits at even parcels; cases 1, 2 and 4 and the part_* registers are removed.
  - instr_compressed_o=0, instr_partial_o=0.
  - skip_r uses only even parcel indices (redirect_pc_i[1] is ignored).
  - The cursor steps by 2.

Test Plan:
1. Packet pc=0x80000000, data={16'h4505,16'h4501}, yumi held high -> cycle+1: 0x00004501 @0x80000000, c=1; cycle+2: 0x00004505 @0x80000002, c=1, fetch_ready_o=1 in that cycle.
2. Packet pc=0x80000000, data=32'h00A00513 -> one instruction 0x00A00513 @0x80000000, c=0, partial=0; buffer frees on yumi.
3. Straddle:
   - Packets: pkt0 @0x80000000 = {16'h0513,16'h4501}; pkt1 @0x80000004 = {16'h4505,16'h00A0}.
   - Response: 0x00004501 @0x80000000, then one bubble, then 0x00A00513 @0x80000002 with partial=1, then 0x00004505 @0x80000006.
4. Redirect_pc=0x80000102, then packet @0x80000100 = {16'h4505,16'h4501} -> only 0x00004505 @0x80000102 is emitted.
5. Partial 0x0513 held at part_pc 0x80000002, next packet @0x80000200 -> partial dropped; first output is parcel 0 @0x80000200.
6. Async reset_i asserted mid-packet, then the same packet resent -> instr_v_o drops immediately with no stale output; after reset the first output is parcel 0 of the new packet.
